// File: rtl/tpa_regbank.sv
// tpa_regbank: a register bank shared by two masters that run concurrently.
// The host side (RIM) does single-cycle accesses. The two-wire side (TWM) uses
// a clk-sampled, LSB-first frame on SDA. A TWM write is shifted in and then
// committed as one whole word.
// Build option: define TPA_PARITY_EN to add an even-parity bit after the data
// bits in both directions. A write whose parity bit mismatches is dropped and
// sets twm_err.
//
// state  | meaning
// IDLE   | waiting for a start bit (SDA low)
// CMD    | sampling the command bit (1 = write, 0 = read)
// ADDR   | shifting in AW address bits
// WDATA  | shifting in DW write-data bits
// PAR    | parity bit: sampled on a write, driven on a read (TPA_PARITY_EN only)
// COMMIT | writing the buffered word into the bank
// TURN   | read preamble: Z, then 1, then 0; the word is snapshotted in cycle 0
// RDATA  | driving DW read-data bits
// STOP   | driving the stop bit (1)
module tpa_regbank #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          SCL,
  inout  wire           SDA,
  input  logic          cfg_req,
  input  logic          cfg_cmd,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  output logic          cfg_rdy,
  output logic [DW-1:0] cfg_rdata,
  output logic          twm_busy,
  output logic          twm_err
);

  localparam int MX    = (AW > DW) ? AW : DW;
  localparam int CW    = $clog2(MX) + 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
`ifdef TPA_PARITY_EN
    PAR,
`endif
    COMMIT,
    TURN,
    RDATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_wr;
  logic [AW-1:0] twm_addr;
  logic [DW-1:0] wshift;
  logic [DW-1:0] rshift;
`ifdef TPA_PARITY_EN
  logic          rpar;
`endif
  logic [DW-1:0] bank [DEPTH];
  logic          sda_in;
  logic          sda_oe;
  logic          sda_do;
  logic          rim_wr;
  logic          scl_unused;

  // SCL exists only so the pin-out stays compatible.
  assign scl_unused = SCL;

  // Only a solid 0 counts as low. X or Z on the line reads as an idle-high bus.
  assign sda_in = (SDA === 1'b0) ? 1'b0 : 1'b1;
  assign SDA    = sda_oe ? sda_do : 1'bz;

  assign rim_wr = cfg_req & ~cfg_rdy & cfg_cmd;

  // Bank storage. TWM COMMIT is written after the RIM write, so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= RST_VAL;
    end else begin
      if (rim_wr) bank[cfg_addr] <= cfg_wdata;
      if (state == COMMIT) bank[twm_addr] <= wshift;
    end
  end

  // RIM engine: accept a request when idle, pulse cfg_rdy once, then force one idle cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_rdy   <= 1'b0;
      cfg_rdata <= '0;
    end else if (cfg_rdy) begin
      cfg_rdy <= 1'b0;
    end else if (cfg_req) begin
      cfg_rdy <= 1'b1;
      if (!cfg_cmd) cfg_rdata <= bank[cfg_addr];
    end
  end

  // TWM frame FSM. The counter restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_wr    <= 1'b0;
      twm_addr <= '0;
      wshift   <= '0;
      rshift   <= '0;
`ifdef TPA_PARITY_EN
      rpar     <= 1'b0;
`endif
      twm_busy <= 1'b0;
      twm_err  <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!sda_in) begin
            state    <= CMD;
            twm_busy <= 1'b1;
            twm_err  <= 1'b0;
          end
        end
        CMD: begin
          is_wr <= sda_in;
          state <= ADDR;
          cnt   <= '0;
        end
        ADDR: begin
          twm_addr <= {sda_in, twm_addr[AW-1:1]};
          if (cnt == CW'(AW - 1)) begin
            cnt   <= '0;
            state <= is_wr ? WDATA : TURN;
          end
        end
        WDATA: begin
          wshift <= {sda_in, wshift[DW-1:1]};
          if (cnt == CW'(DW - 1)) begin
            cnt <= '0;
`ifdef TPA_PARITY_EN
            state <= PAR;
`else
            state <= COMMIT;
`endif
          end
        end
`ifdef TPA_PARITY_EN
        PAR: begin
          cnt <= '0;
          if (!is_wr) begin
            state <= STOP;
          end else if (sda_in != ^wshift) begin
            twm_err  <= 1'b1;
            twm_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= COMMIT;
          end
        end
`endif
        COMMIT: begin
          cnt      <= '0;
          twm_busy <= 1'b0;
          state    <= IDLE;
        end
        TURN: begin
          if (cnt == '0) begin
            rshift <= bank[twm_addr];
`ifdef TPA_PARITY_EN
            rpar   <= ^bank[twm_addr];
`endif
          end
          if (cnt == CW'(2)) begin
            cnt   <= '0;
            state <= RDATA;
          end
        end
        RDATA: begin
          rshift <= rshift >> 1;
          if (cnt == CW'(DW - 1)) begin
            cnt <= '0;
`ifdef TPA_PARITY_EN
            state <= PAR;
`else
            state <= STOP;
`endif
          end
        end
        STOP: begin
          if (!sda_in) twm_err <= 1'b1;
          cnt      <= '0;
          twm_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          cnt      <= '0;
          twm_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // SDA drive is decoded from registered state, so an async reset releases the line at once.
  always_comb begin
    sda_oe = 1'b0;
    sda_do = 1'b1;
    case (state)
      TURN: begin
        sda_oe = (cnt != '0);
        sda_do = (cnt == CW'(1));
      end
      RDATA: begin
        sda_oe = 1'b1;
        sda_do = rshift[0];
      end
`ifdef TPA_PARITY_EN
      PAR: begin
        sda_oe = ~is_wr;
        sda_do = rpar;
      end
`endif
      STOP: begin
        sda_oe = 1'b1;
        sda_do = 1'b1;
      end
      default: begin
        sda_oe = 1'b0;
        sda_do = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tpa_regbank.sv
// Directed bench for tpa_regbank with the default parameters (AW=8, DW=16, RST_VAL=0).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_tpa_regbank;

  logic        clk;
  logic        reset;
  logic        SCL;
  wire         SDA;
  logic        cfg_req;
  logic        cfg_cmd;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_rdy;
  logic [15:0] cfg_rdata;
  logic        twm_busy;
  logic        twm_err;

  logic        tb_sda_oe;
  logic        tb_sda_do;

  int vecs = 0;
  int errs = 0;

  assign SDA = tb_sda_oe ? tb_sda_do : 1'bz;

  tpa_regbank dut (
    .clk       (clk),
    .reset     (reset),
    .SCL       (SCL),
    .SDA       (SDA),
    .cfg_req   (cfg_req),
    .cfg_cmd   (cfg_cmd),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdy   (cfg_rdy),
    .cfg_rdata (cfg_rdata),
    .twm_busy  (twm_busy),
    .twm_err   (twm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    tb_sda_do = b;
  endtask

  // One RIM access. The bus is also returned to idle-high here, because this
  // task often runs straight after the last bit of a TWM write frame.
  task automatic rim(input logic wr, input logic [7:0] a, input logic [15:0] wd,
                     output logic [15:0] rd);
    int n;
    @(negedge clk);
    tb_sda_do = 1'b1;
    cfg_req   = 1'b1;
    cfg_cmd   = wr;
    cfg_addr  = a;
    cfg_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_rdy && n < 4);
    chk("rim_latency", n, 1);
    rd = cfg_rdata;
    cfg_req = 1'b0;
    @(negedge clk);
    chk("rim_rdy_drop", cfg_rdy, 0);
  endtask

  task automatic twm_head(input logic wr, input logic [7:0] a);
    drive_bit(1'b0);
    chk("busy_idle", twm_busy, 0);
    drive_bit(wr);
    chk("busy_rise", twm_busy, 1);
    chk("err_clr_at_start", twm_err, 0);
    for (int i = 0; i < 8; i++) drive_bit(a[i]);
  endtask

  // Returns just after the last bit is driven; the next rising edge enters COMMIT.
  task automatic twm_write(input logic [7:0] a, input logic [15:0] d, input logic bad_par);
    twm_head(1'b1, a);
    for (int i = 0; i < 16; i++) drive_bit(d[i]);
`ifdef TPA_PARITY_EN
    drive_bit((^d) ^ bad_par);
`else
    if (bad_par) drive_bit(1'b1);
`endif
  endtask

  task automatic twm_read(input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] got;
    twm_head(1'b0, a);
    @(negedge clk);
    chk("turn_z", dut.sda_oe, 0);
    tb_sda_oe = 1'b0;
    @(negedge clk);
    chk("turn_one", SDA, 1);
    @(negedge clk);
    chk("turn_zero", SDA, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      got[i] = SDA;
    end
    chk("rdata_word", got, exp);
`ifdef TPA_PARITY_EN
    @(negedge clk);
    chk("rdata_par", SDA, ^exp);
`endif
    @(negedge clk);
    chk("stop_bit", SDA, 1);
    chk("busy_in_stop", twm_busy, 1);
    @(negedge clk);
    chk("sda_released", dut.sda_oe, 0);
    chk("busy_fall", twm_busy, 0);
    tb_sda_oe = 1'b1;
    tb_sda_do = 1'b1;
  endtask

  initial begin
    logic [15:0] rd;
    reset     = 1'b1;
    SCL       = 1'b1;
    cfg_req   = 1'b0;
    cfg_cmd   = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    tb_sda_oe = 1'b1;
    tb_sda_do = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_rdy", cfg_rdy, 0);
    chk("rst_rdata", cfg_rdata, 0);
    chk("rst_busy", twm_busy, 0);
    chk("rst_err", twm_err, 0);
    chk("rst_sda_z", dut.sda_oe, 0);

    rim(1'b0, 8'h00, 16'h0, rd);
    chk("rim_rd_00", rd, 16'h0000);
    chk("rim_sda_z", dut.sda_oe, 0);

    rim(1'b1, 8'h3C, 16'hBEEF, rd);

    // Hold cfg_req across two accesses: ready pattern must be 1, 0, 1.
    @(negedge clk);
    cfg_req = 1'b1; cfg_cmd = 1'b0; cfg_addr = 8'h3C;
    @(negedge clk);
    chk("hold_rdy_a", cfg_rdy, 1);
    chk("hold_rdata", cfg_rdata, 16'hBEEF);
    @(negedge clk);
    chk("hold_rdy_gap", cfg_rdy, 0);
    @(negedge clk);
    chk("hold_rdy_b", cfg_rdy, 1);
    cfg_req = 1'b0;
    @(negedge clk);
    chk("hold_rdy_end", cfg_rdy, 0);

    twm_read(8'h3C, 16'hBEEF);

    // The RIM read lands on the COMMIT edge, so it must still see the old word.
    twm_write(8'h05, 16'h1234, 1'b0);
    rim(1'b0, 8'h05, 16'h0, rd);
    chk("commit_old", rd, 16'h0000);
    rim(1'b0, 8'h05, 16'h0, rd);
    chk("commit_new", rd, 16'h1234);

    // A RIM write on the COMMIT edge to the same address: the TWM word wins.
    twm_write(8'h05, 16'h5555, 1'b0);
    rim(1'b1, 8'h05, 16'hAAAA, rd);
    rim(1'b0, 8'h05, 16'h0, rd);
    chk("collision", rd, 16'h5555);

    twm_read(8'h05, 16'h5555);

`ifdef TPA_PARITY_EN
    rim(1'b1, 8'h22, 16'h1111, rd);
    twm_write(8'h22, 16'h0003, 1'b1);
    @(negedge clk);
    tb_sda_do = 1'b1;
    chk("par_err_set", twm_err, 1);
    chk("par_busy_off", twm_busy, 0);
    rim(1'b0, 8'h22, 16'h0, rd);
    chk("par_word_kept", rd, 16'h1111);
    chk("par_err_sticky", twm_err, 1);
    twm_write(8'h22, 16'h00F1, 1'b0);
    rim(1'b0, 8'h22, 16'h0, rd);
    chk("par_commit_old", rd, 16'h1111);
    rim(1'b0, 8'h22, 16'h0, rd);
    chk("par_commit_new", rd, 16'h00F1);
`else
    chk("err_quiet", twm_err, 0);
`endif

    // Reset partway through the write data: nothing is committed and the FSM stays idle.
    rim(1'b1, 8'h10, 16'h7777, rd);
    twm_head(1'b1, 8'h10);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_sda_z", dut.sda_oe, 0);
    chk("mid_rst_busy", twm_busy, 0);
    tb_sda_do = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_idle", twm_busy, 0);
    rim(1'b0, 8'h10, 16'h0, rd);
    chk("mid_rst_word", rd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
